// File: rtl/dmem_bridge.sv
// Data-memory bridge: CPU load/store port plus buffered camera writes sharing RAM port A.
// Optional DMEM_BRIDGE_STATS_EN adds pop and stall counters; otherwise the stat outputs read 0.
module dmem_bridge #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int CAM_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [31:0]       stat_cam_wr,
    output logic [31:0]       stat_stall
);

    localparam int PTR_W = $clog2(CAM_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CAM_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  fifo_addr_q [CAM_FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [CAM_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               fifo_full, fifo_empty, push, pop, in_range;
    logic [ADDR_W-1:0]  cpu_word;
    logic [1:0]         unused_addr_bits;

    assign cpu_word         = cpu_addr[ADDR_W+1:2];
    assign in_range         = (cpu_addr[31:ADDR_W+2] == '0);
    assign unused_addr_bits = cpu_addr[1:0];

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign cam_ready  = !fifo_full;
    assign push       = cam_valid && cam_ready;
    assign cpu_rdata  = rdata_q;
    assign cpu_err    = err_q;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        pop         = 1'b0;
        cpu_stall   = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_full) begin
                    pop       = 1'b1;
                    cpu_stall = cpu_we || cpu_re;
                end else if (cpu_we) begin
                    if (in_range) begin
                        ram_address = cpu_word;
                        ram_data    = cpu_wdata;
                        ram_wren    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cpu_re) begin
                    cpu_stall = 1'b1;
                    if (in_range) begin
                        ram_address = cpu_word;
                        state_d     = RD_WAIT;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RD_DONE;
                    end
                end else begin
                    pop = !fifo_empty;
                end
            end
            RD_WAIT: begin
                cpu_stall = 1'b1;
                rdata_d   = ram_q;
                pop       = !fifo_empty;
                state_d   = RD_DONE;
            end
            RD_DONE: begin
                pop     = !fifo_empty;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pop shares the single RAM port; the FSM only pops when the CPU is not using it.
        if (pop) begin
            ram_address = fifo_addr_q[rd_ptr_q];
            ram_data    = fifo_data_q[rd_ptr_q];
            ram_wren    = 1'b1;
        end
        if (!reset) begin
            pop         = 1'b0;
            cpu_stall   = 1'b0;
            ram_address = '0;
            ram_data    = '0;
            ram_wren    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cam_addr;
            fifo_data_q[wr_ptr_q] <= cam_data;
        end
    end

`ifdef DMEM_BRIDGE_STATS_EN
    logic [31:0] stat_cam_wr_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_cam_wr_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (pop)       stat_cam_wr_q <= stat_cam_wr_q + 32'd1;
            if (cpu_stall) stat_stall_q  <= stat_stall_q + 32'd1;
        end
    end

    assign stat_cam_wr = stat_cam_wr_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_cam_wr = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: stimulus queues expected RAM writes and load data,
// a negedge monitor pops and compares whenever the DUT issues a write or completes a load.
module tb_dmem_bridge;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_we = 1'b0;
    logic              cpu_re = 1'b0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall, cpu_err;
    logic              cam_valid = 1'b0;
    logic [ADDR_W-1:0] cam_addr = '0;
    logic [DATA_W-1:0] cam_data = '0;
    logic              cam_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q = '0;
    logic [31:0]       stat_cam_wr, stat_stall;

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CAM_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_data(cam_data), .cam_ready(cam_ready),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .stat_cam_wr(stat_cam_wr), .stat_stall(stat_stall)
    );

    // Port A of the video RAM: registered read, one cycle latency.
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_wr[$];
    logic [DATA_W-1:0] exp_rd[$];

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.data = d;
        exp_wr.push_back(w);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        logic [DATA_W-1:0] r;
        if (reset) begin
            if (ram_wren) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ram_write: got addr 0x%0h data 0x%0h, expected no write",
                             ram_address, ram_data);
                end else begin
                    e = exp_wr.pop_front();
                    check("ram_wr_addr", 32'(ram_address), 32'(e.addr));
                    check("ram_wr_data", ram_data, e.data);
                end
            end
            if (cpu_re && !cpu_we && !cpu_stall) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load_done: got rdata 0x%0h, expected no load", cpu_rdata);
                end else begin
                    r = exp_rd.pop_front();
                    check("cpu_rdata", cpu_rdata, r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_load(input logic [31:0] a, input logic [31:0] exp, input int exp_stalls,
                            input string name);
        int stalls = 0;
        exp_rd.push_back(exp);
        cpu_re   = 1'b1;
        cpu_addr = a;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            step();
        end
        check(name, 32'(stalls), 32'(exp_stalls));
        step();
        cpu_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_cam_ready", 32'(cam_ready), 1);
        check("rst_wren", 32'(ram_wren), 0);
        check("rst_err", 32'(cpu_err), 0);
        check("rst_rdata", cpu_rdata, 0);
        step();

        // In-range store then load
        push_wr(4, 32'hDEADBEEF);
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("store_addr", 32'(ram_address), 4);
        check("store_wren", 32'(ram_wren), 1);
        check("store_stall", 32'(cpu_stall), 0);
        step();
        cpu_we = 1'b0;
        cpu_load(32'h10, 32'hDEADBEEF, 2, "load_stalls");

        @(negedge clk);
`ifdef DMEM_BRIDGE_STATS_EN
        check("stat_stall_after_load", stat_stall, 2);
`else
        check("stat_stall_after_load", stat_stall, 0);
`endif
        check("stat_cam_wr_after_load", stat_cam_wr, 0);
        step();

        // Out-of-range store and load
        cpu_we = 1'b1; cpu_addr = 32'h0004_0000; cpu_wdata = 32'h12345678;
        @(negedge clk);
        check("oob_store_wren", 32'(ram_wren), 0);
        check("oob_store_stall", 32'(cpu_stall), 0);
        step();
        cpu_we = 1'b0;
        @(negedge clk);
        check("oob_err", 32'(cpu_err), 1);
        step();
        cpu_load(32'h0004_0000, 32'h0, 1, "oob_load_stalls");

        // Reset in the middle of a read
        cpu_re = 1'b1; cpu_addr = 32'h10;
        step();
        reset = 1'b0; cpu_re = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        check("midrd_stall", 32'(cpu_stall), 0);
        check("midrd_cam_ready", 32'(cam_ready), 1);
        check("midrd_wren", 32'(ram_wren), 0);
        check("midrd_err", 32'(cpu_err), 0);
        check("midrd_rdata", cpu_rdata, 0);
        step();

        // Fill the FIFO while CPU stores own the port, then a load meets a full FIFO
        for (int i = 0; i < 4; i++) begin
            cam_valid = 1'b1; cam_addr = ADDR_W'(i); cam_data = 32'hA0 + 32'(i);
            cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(4 * i); cpu_wdata = 32'h1111_0000 + 32'(i);
            push_wr(32'h40 + i, 32'h1111_0000 + 32'(i));
            @(negedge clk);
            check("fill_cam_ready", 32'(cam_ready), 1);
            step();
        end
        cam_valid = 1'b0; cpu_we = 1'b0;
        for (int i = 0; i < 4; i++) push_wr(i, 32'hA0 + 32'(i));
        fork
            begin
                @(negedge clk);
                check("full_cam_ready", 32'(cam_ready), 0);
                check("full_pop_addr", 32'(ram_address), 0);
                check("full_pop_stall", 32'(cpu_stall), 1);
            end
        join_none
        cpu_load(32'h10, 32'hDEADBEEF, 3, "load_behind_full_stalls");
        for (int i = 0; i < 4; i++) cpu_load(32'(4 * i), 32'hA0 + 32'(i), 2, "cam_word_load_stalls");

        // Full FIFO with cam_valid held: pop without push, then push next cycle
        for (int i = 0; i < 4; i++) begin
            cam_valid = 1'b1; cam_addr = ADDR_W'(8 + i); cam_data = 32'hB0 + 32'(i);
            cpu_we = 1'b1; cpu_addr = 32'h200 + 32'(4 * i); cpu_wdata = 32'h2222_0000 + 32'(i);
            push_wr(32'h80 + i, 32'h2222_0000 + 32'(i));
            @(negedge clk);
            step();
        end
        cpu_we = 1'b0;
        cam_addr = ADDR_W'(12); cam_data = 32'hB4;
        for (int i = 0; i < 5; i++) push_wr(8 + i, 32'hB0 + 32'(i));
        @(negedge clk);
        check("held_full_cam_ready", 32'(cam_ready), 0);
        check("held_full_wren", 32'(ram_wren), 1);
        check("held_full_stall", 32'(cpu_stall), 0);
        step();
        @(negedge clk);
        check("after_pop_cam_ready", 32'(cam_ready), 1);
        step();
        cam_valid = 1'b0;
        repeat (6) step();

        @(negedge clk);
        check("pending_writes", 32'(exp_wr.size()), 0);
        check("pending_loads", 32'(exp_rd.size()), 0);
`ifdef DMEM_BRIDGE_STATS_EN
        check("stat_cam_wr_final", stat_cam_wr, 9);
        check("stat_stall_final", stat_stall, 11);
`else
        check("stat_cam_wr_final", stat_cam_wr, 0);
        check("stat_stall_final", stat_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
